noc_outport_arbiter: RTL and testbench
======================================

Name: noc_outport_arbiter

Overview:
- Round-robin scheduler for one router output port. Shares the port among NREQ requesters: four neighbour input queues plus the local node queue.
- Selects one requester whose head packet is pending and latches its 32-bit packet. Serialises the packet as four bytes on the 8-bit put/payload link toward the downstream router or node.
- Pops the winner's queue once the packet is fully sent. One instance per router output port.

Parameters:
- NREQ, 5, number of requesters (2..8).
- IDXW, 3, width of grant_idx; must satisfy 2**IDXW >= NREQ.

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset
- req  input  NREQ  req[i]=1: requester i has a head packet (its queue is non-empty)
- pkt_in  input  NREQ*32  flattened head packets; requester i occupies bits [32*i+31:32*i]; valid while req[i]=1
- pop  output  NREQ  one-hot, one-cycle pulse; removes the head of requester i's queue
- free_downstream  input  1  downstream can accept one complete 4-byte packet
- put_out  output  1  payload_out carries a valid byte this cycle
- payload_out  output  8  serialised packet byte
- busy  output  1  a packet is in transfer
- grant_idx  output  IDXW  index of the current or most recent winner

Behaviour:
- Reset (already decided): reset_n, synchronous, active-low; clock clock.
  - Reset values: state IDLE, put_out=0, payload_out=0, pop=0, busy=0, grant_idx=0, rr_ptr=0, byte counter=0, packet latch=0.
  - Reset mid-packet aborts the transfer. No pop is issued, so the packet stays queued.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- FSM state IDLE:
  - If free_downstream=1 and |req=1 at a clock edge: choose the winner w.
    - w is the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... NREQ-1, then 0, ... with wrap.
    - Latch pkt_in[w], set grant_idx=w, rr_ptr <= (w+1) mod NREQ, byte count=3, go to SEND.
  - Otherwise remain in IDLE. req is ignored while free_downstream=0. rr_ptr is unchanged when no grant occurs.
- FSM state SEND, 4 cycles:
  - put_out=1 and busy=1.
  - payload_out = latched bits [8*cnt+7:8*cnt], MSB byte first: cnt goes 3, 2, 1, 0.
  - free_downstream is not re-sampled during SEND; downstream guaranteed space for the whole packet at grant.
  - On the cnt=0 cycle, pop[grant_idx]=1 for exactly that cycle. Next state is IDLE.
- Mandatory IDLE gap: at least one IDLE cycle separates packets. The popped queue's new head is therefore stable before re-arbitration.
  - Maximum throughput is 4 bytes per 5 cycles.
- Grant timing: grant at edge t gives the first byte in the cycle after t, and pop in the cycle after edge t+3.
- Simultaneous events:
  - req changes or pkt_in changes during SEND are ignored; the packet is latched.
  - A requester dropping req during SEND is still popped. Requesters must hold their head until popped.
- Fairness: any requester holding req continuously is granted within NREQ packets.
- Single requester: the same index wins every arbitration. rr_ptr still advances past it.
- Non-request state: pop is all-zero except in the cnt=0 cycle; put_out=0 in IDLE; payload_out=0 in IDLE.

Test Plan:
- Reset then idle: req=0, free=1 for 10 cycles -> put_out, pop, busy stay 0; grant_idx=0.
- Single packet: req=5'b00100, pkt_in[2]=32'hDEADBEEF, free=1.
  - Payload bytes DE, AD, BE, EF on 4 consecutive put_out cycles starting one cycle after grant.
  - pop=5'b00100 with byte EF; then 1 IDLE cycle.
- Round-robin: req=5'b11111 held, free=1.
  - Grant order 0, 1, 2, 3, 4, 0; each grant separated by 5 cycles; exactly one pop per packet.
- Backpressure: req=5'b00001, free=0 for 8 cycles, then 1.
  - No put_out while free=0; transfer starts the cycle after free rises.
  - Dropping free mid-SEND does not stall the remaining bytes.
- Pointer wrap/skip: rr_ptr=4 after a grant to 3; req=5'b01010 -> next winner 1, then 3.
- Reset mid-packet: assert reset_n=0 on the byte-2 cycle.
  - put_out=0 and pop=0 next cycle.
  - After release, the same packet is re-sent in full from requester 0's priority position.

Source files
------------

// File: rtl/noc_outport_arbiter.sv
// noc_outport_arbiter: round-robin scheduler for one router output port.
// Picks one pending requester and latches its 32-bit head packet.
// Sends the packet MSB byte first as four bytes on put_out/payload_out.
// Pops the winner's queue in the cycle that carries the last byte.
//
// Handshake: a requester raises req[i] while its queue head is on
// pkt_in[32*i +: 32] and holds that head until pop[i] pulses. A grant happens
// only when free_downstream=1 at an IDLE edge, which promises room for the
// whole packet. Once granted, the four bytes leave on consecutive cycles with
// put_out=1 and are never stalled.
module noc_outport_arbiter #(
    parameter int NREQ = 5,
    parameter int IDXW = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*32-1:0] pkt_in,
    output logic [NREQ-1:0]    pop,
    input  logic               free_downstream,
    output logic               put_out,
    output logic [7:0]         payload_out,
    output logic               busy,
    output logic [IDXW-1:0]    grant_idx
);

    // The search window wraps around, so req is laid out twice end to end.
    // The last bit of the second copy is never reached.
    localparam int SW = $clog2(2 * NREQ - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        cnt;
    logic [31:0]       pkt_q;
    logic [IDXW-1:0]   rr_ptr;
    logic [2*NREQ-2:0] req_dbl;
    logic [SW-1:0]     sel;
    logic              found;
    logic [IDXW-1:0]   win;
    logic [31:0]       pkt_sel;
    logic              grant;

    assign req_dbl = {req[NREQ-2:0], req};
    assign grant   = (state == IDLE) && free_downstream && found;

    // Round-robin search: the first pending requester at or after rr_ptr, with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = SW'(int'(rr_ptr) + k);
            if (!found && req_dbl[sel]) begin
                found = 1'b1;
                win   = IDXW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Head-packet mux for the current search winner.
    always_comb begin
        pkt_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDXW'(i)) begin
                pkt_sel = pkt_in[32*i +: 32];
            end
        end
    end

    // State register. A reset mid-packet returns to IDLE without a pop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. SEND always returns to IDLE after the last byte, which forces the gap cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = SEND;
            SEND:    if (cnt == 2'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the winner and advance the pointer on grant, then count the bytes down.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt       <= 2'd0;
            pkt_q     <= 32'h0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            cnt       <= 2'd3;
            pkt_q     <= pkt_sel;
            grant_idx <= win;
            rr_ptr    <= (win == IDXW'(NREQ - 1)) ? '0 : win + 1'b1;
        end else if (state == SEND) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Outputs decoded from registered state only; IDLE drives all zeros.
    always_comb begin
        put_out     = 1'b0;
        busy        = 1'b0;
        payload_out = 8'h00;
        pop         = '0;
        if (state == SEND) begin
            put_out = 1'b1;
            busy    = 1'b1;
            case (cnt)
                2'd3:    payload_out = pkt_q[31:24];
                2'd2:    payload_out = pkt_q[23:16];
                2'd1:    payload_out = pkt_q[15:8];
                default: payload_out = pkt_q[7:0];
            endcase
            if (cnt == 2'd0) begin
                pop = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// tb_noc_outport_arbiter: directed scenarios plus randomized traffic.
// Outputs are compared every cycle against a queue-based model of the port.
module tb_noc_outport_arbiter;

    localparam int NREQ = 5;
    localparam int IDXW = 3;
    localparam int QD   = 16;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*32-1:0] pkt_in = '0;
    logic [NREQ-1:0]    pop;
    logic               free_downstream = 1'b1;
    logic               put_out;
    logic [7:0]         payload_out;
    logic               busy;
    logic [IDXW-1:0]    grant_idx;

    noc_outport_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req             (req),
        .pkt_in          (pkt_in),
        .pop             (pop),
        .free_downstream (free_downstream),
        .put_out         (put_out),
        .payload_out     (payload_out),
        .busy            (busy),
        .grant_idx       (grant_idx)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // exp_q holds the bytes still to appear on the link; its front is this cycle's byte.
    logic [7:0]  exp_q[$];
    int          m_ptr = 0;
    int          m_grant = 0;
    int          m_w;
    logic [31:0] m_pkt;

    always @(posedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            m_ptr   = 0;
            m_grant = 0;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (free_downstream && req != '0) begin
            m_w = -1;
            for (int k = 0; k < NREQ; k++)
                if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
            m_pkt = pkt_in[32*m_w +: 32];
            for (int b = 3; b >= 0; b--) exp_q.push_back(m_pkt[8*b +: 8]);
            m_grant = m_w;
            m_ptr   = (m_w + 1) % NREQ;
        end
    end

    function automatic logic [NREQ-1:0] exp_pop();
        return (exp_q.size() == 1) ? (NREQ'(1) << m_grant) : '0;
    endfunction

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clock) begin
        if (check_en) begin
            check("put_out", 32'(put_out), 32'(exp_q.size() != 0));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("payload_out", 32'(payload_out), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
            check("pop", 32'(pop), 32'(exp_pop()));
            check("grant_idx", 32'(grant_idx), 32'(m_grant));
        end
    end

    // ---------------- requester queues / driver tasks ----------------
    logic [31:0] rq_mem[NREQ][QD];
    int          rq_cnt[NREQ];

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (rq_cnt[i] != 0);
            pkt_in[32*i +: 32] = (rq_cnt[i] != 0) ? rq_mem[i][0] : $urandom();
        end
    endtask

    task automatic push_pkt(input int i, input logic [31:0] d);
        if (rq_cnt[i] < QD) begin
            rq_mem[i][rq_cnt[i]] = d;
            rq_cnt[i]++;
        end
        drive_req();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) rq_cnt[i] = 0;
        drive_req();
    endtask

    // Advance to the next sampling point. Queues popped this cycle drop their head.
    task automatic tick();
        logic [NREQ-1:0] mp;
        @(negedge clock);
        mp = exp_pop();
        for (int i = 0; i < NREQ; i++) begin
            if (mp[i] && rq_cnt[i] > 0) begin
                for (int j = 0; j < QD - 1; j++) rq_mem[i][j] = rq_mem[i][j+1];
                rq_cnt[i]--;
            end
        end
        drive_req();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_queues();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]      lit_b[4];
    logic [NREQ-1:0] pop_rec[6];
    int              cyc_rec[6];
    int              n_pops;
    int              ri;
    bit              seen;

    initial begin
        for (int i = 0; i < NREQ; i++) rq_cnt[i] = 0;
        drive_req();

        // Reset, then idle with free=1 and no requests.
        reset_n = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (10) begin
            tick();
            check("idle_put", 32'(put_out), 32'h0);
            check("idle_pop", 32'(pop), 32'h0);
            check("idle_grant", 32'(grant_idx), 32'h0);
        end

        // A single packet from requester 2.
        lit_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_pkt(2, 32'hDEADBEEF);
        for (int b = 0; b < 4; b++) begin
            tick();
            check("single_put", 32'(put_out), 32'h1);
            check("single_byte", 32'(payload_out), 32'(lit_b[b]));
            check("single_pop", 32'(pop), (b == 3) ? 32'h4 : 32'h0);
        end
        tick();
        check("single_gap_put", 32'(put_out), 32'h0);
        check("single_grant", 32'(grant_idx), 32'h2);

        // Round-robin with every requester pending.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push_pkt(i, 32'hA0000000 | (i << 8) | 1);
            push_pkt(i, 32'hA0000000 | (i << 8) | 2);
        end
        n_pops = 0;
        for (int j = 0; j < 6; j++) begin
            pop_rec[j] = '0;
            cyc_rec[j] = -1;
        end
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (pop != '0) begin
                if (n_pops < 6) begin
                    pop_rec[n_pops] = pop;
                    cyc_rec[n_pops] = c;
                end
                n_pops++;
            end
        end
        check("rr_pop_count", 32'(n_pops), 32'h6);
        for (int j = 0; j < 6; j++) begin
            check("rr_order", 32'(pop_rec[j]), 32'(1 << (j % NREQ)));
            check("rr_spacing", 32'(cyc_rec[j]), 32'(4 + 5 * j));
        end

        // Backpressure: nothing moves while free=0, then no stall once started.
        do_reset();
        free_downstream = 1'b0;
        push_pkt(0, 32'h01234567);
        repeat (8) begin
            tick();
            check("bp_hold_put", 32'(put_out), 32'h0);
        end
        free_downstream = 1'b1;
        lit_b = '{8'h01, 8'h23, 8'h45, 8'h67};
        for (int b = 0; b < 4; b++) begin
            tick();
            free_downstream = 1'b0;
            check("bp_put", 32'(put_out), 32'h1);
            check("bp_byte", 32'(payload_out), 32'(lit_b[b]));
            check("bp_pop", 32'(pop), (b == 3) ? 32'h1 : 32'h0);
        end
        free_downstream = 1'b1;

        // Pointer wrap and skip: a grant to 3 leaves rr_ptr=4, so 1 wins before 3.
        push_pkt(3, 32'h33333333);
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (pop != '0) seen = 1'b1;
        end
        check("skip_first_pop", 32'(pop), 32'h8);
        push_pkt(1, 32'h11111111);
        push_pkt(3, 32'h33330000);
        n_pops = 0;
        for (int j = 0; j < 2; j++) pop_rec[j] = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pop != '0 && n_pops < 2) begin
                pop_rec[n_pops] = pop;
                n_pops++;
            end
        end
        check("skip_second_pop", 32'(pop_rec[0]), 32'h2);
        check("skip_third_pop", 32'(pop_rec[1]), 32'h8);

        // Reset during byte 2 aborts without a pop; the packet is re-sent whole.
        do_reset();
        push_pkt(0, 32'hCAFEF00D);
        tick();
        check("rst_first_byte", 32'(payload_out), 32'hCA);
        tick();
        check("rst_second_byte", 32'(payload_out), 32'hFE);
        reset_n = 1'b0;
        tick();
        check("rst_put", 32'(put_out), 32'h0);
        check("rst_pop", 32'(pop), 32'h0);
        reset_n = 1'b1;
        lit_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        for (int b = 0; b < 4; b++) begin
            tick();
            check("resend_byte", 32'(payload_out), 32'(lit_b[b]));
            check("resend_pop", 32'(pop), (b == 3) ? 32'h1 : 32'h0);
        end

        // Randomized traffic, backpressure and occasional resets.
        repeat (3000) begin
            tick();
            if ($urandom_range(0, 3) == 0) begin
                ri = $urandom_range(0, NREQ - 1);
                push_pkt(ri, $urandom());
            end
            free_downstream = ($urandom_range(0, 9) < 7);
            reset_n = ($urandom_range(0, 599) != 0);
        end

        // Drain.
        reset_n = 1'b1;
        free_downstream = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
